// File: rtl/data_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_queue_pkg
// Purpose  : Shared definitions for the data_queue slice: the clog2 constant
//            function used for pointer/occupancy widths and the two full-queue
//            policy encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package data_queue_pkg;

    // Full-queue policy encodings, matched against the DROP_OLDEST parameter.
    localparam bit c_drop_newest = 1'b0;
    localparam bit c_drop_oldest = 1'b1;

    // Ceiling log2 for elaboration-time width calculations; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage : data_queue_pkg
`default_nettype wire

// File: rtl/data_queue_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : data_queue_sat_counter
// Purpose  : Saturating up-counter that sticks at all-ones; used to tally
//            words lost by data_queue.
// Ports    : clk     - clock
//            rst     - asynchronous active-high clear
//            i_inc   - increment strobe, one count per high cycle
//            o_value - current count
// Revision : 1.0 - initial release
// ============================================================================
module data_queue_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_value
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_inc && (r_value != '1)) begin
            r_value <= r_value + WIDTH'(1);
        end
    end

    assign o_value = r_value;

endmodule : data_queue_sat_counter
`default_nettype wire

// File: rtl/data_queue.sv
`default_nettype none
// ============================================================================
// Module   : data_queue
// Purpose  : Single-clock DEPTH-word queue between a producer write strobe and
//            a consumer valid/retrieved handshake. When full, an incoming word
//            either is discarded (DROP_OLDEST=0) or overwrites the oldest word
//            (DROP_OLDEST=1); every lost word is counted.
// Ports    : clk                - sole clock
//            rst                - asynchronous active-high reset
//            in_data            - producer word
//            in_data_valid      - write strobe, one word per high cycle
//            in_ready           - queue not full
//            out_data           - head word, 0 while empty
//            out_data_valid     - queue holds at least one word
//            out_data_retrieved - consumer pop, honoured only while valid
//            count              - occupancy 0..DEPTH
//            drop_count         - saturating count of lost words
//            overflow           - one-cycle pulse the cycle after a loss
// Revision : 1.0 - initial release
// ============================================================================
module data_queue
    import data_queue_pkg::*;
#(
    parameter int W           = 4,
    parameter int DEPTH       = 4,   // power of two, >= 2
    parameter int DROP_OLDEST = 0,
    parameter int DCW         = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [W-1:0]              in_data,
    input  logic                      in_data_valid,
    output logic                      in_ready,
    output logic [W-1:0]              out_data,
    output logic                      out_data_valid,
    input  logic                      out_data_retrieved,
    output logic [clog2(DEPTH+1)-1:0] count,
    output logic [DCW-1:0]            drop_count,
    output logic                      overflow
);

    localparam int              c_ptr_w     = clog2(DEPTH);
    localparam int              c_cnt_w     = clog2(DEPTH+1);
    localparam logic [c_cnt_w-1:0] c_full   = c_cnt_w'(DEPTH);
    localparam bit              c_overwrite = (DROP_OLDEST == int'(c_drop_oldest));

    logic [W-1:0]       r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_write;
    logic w_rd_adv;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full);
    assign w_push  = in_data_valid;
    // A pop against an empty queue is simply ignored.
    assign w_pop   = out_data_retrieved & ~w_empty;
    // A simultaneous pop frees a slot, so a full queue only loses a word
    // when it is pushed without being popped.
    assign w_drop  = w_push & w_full & ~w_pop;
    // In overwrite mode the write lands on the oldest slot (wr_ptr == rd_ptr
    // when full) and the read pointer steps past it.
    assign w_write  = w_push & (~w_drop | c_overwrite);
    assign w_rd_adv = w_pop | (w_drop & c_overwrite);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop && !w_full) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_w'(1);
            end
            r_overflow <= w_drop;
        end
    end

    // Storage carries no reset; stale contents are masked by out_data gating.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    data_queue_sat_counter #(
        .WIDTH (DCW)
    ) u_drop_counter (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_drop),
        .o_value (drop_count)
    );

    assign in_ready       = ~w_full;
    assign out_data_valid = ~w_empty;
    assign out_data       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count          = r_count;
    assign overflow       = r_overflow;

endmodule : data_queue
`default_nettype wire
